// File: rtl/output_pkg.sv
// Shared constants and helpers for the output result path.
package output_pkg;

    localparam int unsigned RESULT_WIDTH = 64;
    localparam int unsigned MAX_CORES    = 16;

    // Width of a binary index into n lanes; at least one bit, even for a single lane.
    function automatic int unsigned ptr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Round-robin pick: rotate requests so the pointer lane is bit 0, take the lowest set bit,
// then rotate the result back into lane numbering. Purely combinational.
module rr_priority_pick #(
    parameter int unsigned N  = 4,
    parameter int unsigned PW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [PW-1:0] idx_o,
    output logic          any_o
);

    logic [N-1:0] rot;
    logic         found;
    int unsigned  k;
    int unsigned  lane;

    // Rotate, priority-encode, rotate back.
    always_comb begin
        rot   = N'({req_i, req_i} >> ptr_i);
        found = 1'b0;
        k     = 0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!found && rot[i]) begin
                found = 1'b1;
                k     = i;
            end
        end
        lane = 32'(ptr_i) + k;
        if (lane >= N) begin
            lane = lane - N;
        end
        any_o = found;
        idx_o = found ? PW'(lane) : '0;
        gnt_o = found ? (N'(1) << lane) : '0;
    end

endmodule

// File: rtl/output_result_arbiter.sv
// Merges per-core result streams into the output buffer write port, round-robin,
// and registers the buffer fullness flag as a throttle broadcast to the cores.
module output_result_arbiter
    import output_pkg::*;
#(
    parameter int unsigned NUM_CORES  = 4,
    parameter int unsigned WIDTH      = RESULT_WIDTH,
    parameter int unsigned COUNT_BITS = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_CORES-1:0]       coreValid,
    input  logic [NUM_CORES*WIDTH-1:0] coreData,
    output logic [NUM_CORES-1:0]       coreReady,
    input  logic                       bufferSlow,
    output logic                       coreThrottle,
    output logic                       outValid,
    output logic [WIDTH-1:0]           outData,
    output logic [COUNT_BITS-1:0]      resultCount
);

    localparam int unsigned PtrW = ptr_width(NUM_CORES);

    logic [PtrW-1:0]       ptr_q, ptr_d;
    logic                  out_valid_q, out_valid_d;
    logic [WIDTH-1:0]      out_data_q, out_data_d;
    logic                  throttle_q, throttle_d;
    logic [COUNT_BITS-1:0] count_q, count_d;

    logic [NUM_CORES-1:0]  pick_gnt;
    logic [PtrW-1:0]       pick_idx;
    logic                  pick_any;
    logic                  grant;

    rr_priority_pick #(
        .N  (NUM_CORES),
        .PW (PtrW)
    ) u_pick (
        .req_i (coreValid),
        .ptr_i (ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    // Grant decode and next-state; a word offered during reset is never accepted.
    always_comb begin
        grant       = pick_any && !rst;
        coreReady   = rst ? '0 : pick_gnt;
        ptr_d       = ptr_q;
        out_data_d  = out_data_q;
        out_valid_d = grant;
        throttle_d  = bufferSlow;
        count_d     = count_q + (grant ? COUNT_BITS'(1) : COUNT_BITS'(0));
        if (grant) begin
            ptr_d      = (pick_idx == PtrW'(NUM_CORES - 1)) ? '0 : pick_idx + PtrW'(1);
            out_data_d = coreData[pick_idx*WIDTH +: WIDTH];
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            throttle_q  <= 1'b0;
            count_q     <= '0;
        end else begin
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            throttle_q  <= throttle_d;
            count_q     <= count_d;
        end
    end

    assign outValid     = out_valid_q;
    assign outData      = out_data_q;
    assign coreThrottle = throttle_q;
    assign resultCount  = count_q;

endmodule

// File: tb/tb_output_result_arbiter.sv
// Scoreboard bench: the driver predicts each cycle's registered outputs from a simple
// round-robin model and queues them; the monitor pops and compares after each clock edge.
module tb_output_result_arbiter;

    localparam int N  = 4;
    localparam int W  = 64;
    localparam int CB = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    coreValid;
    logic [N*W-1:0]  coreData;
    logic [N-1:0]    coreReady;
    logic            bufferSlow;
    logic            coreThrottle;
    logic            outValid;
    logic [W-1:0]    outData;
    logic [CB-1:0]   resultCount;

    always #5 clk = ~clk;

    output_result_arbiter #(
        .NUM_CORES  (N),
        .WIDTH      (W),
        .COUNT_BITS (CB)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .coreValid    (coreValid),
        .coreData     (coreData),
        .coreReady    (coreReady),
        .bufferSlow   (bufferSlow),
        .coreThrottle (coreThrottle),
        .outValid     (outValid),
        .outData      (outData),
        .resultCount  (resultCount)
    );

    typedef struct {
        logic          v;
        logic [W-1:0]  d;
        logic [CB-1:0] c;
        logic          t;
    } rec_t;

    rec_t sb[$];
    int errors = 0;
    int checks = 0;

    // Reference model state: pointer, last forwarded word, forwarded count.
    int            m_ptr   = 0;
    logic [W-1:0]  m_data  = '0;
    logic [CB-1:0] m_count = '0;

    bit            use_fixed  = 1'b0;
    logic [W-1:0]  fixed_data = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus: drive, check the combinational grant, queue the prediction.
    task automatic step(input logic r, input logic [N-1:0] v, input logic slow);
        logic [N-1:0] exp_rdy;
        int           g;
        int           c;
        rec_t         rec;
        @(negedge clk);
        rst        = r;
        coreValid  = v;
        bufferSlow = slow;
        for (int i = 0; i < N; i++) begin
            coreData[i*W +: W] = use_fixed ? fixed_data : {$urandom, $urandom};
        end
        #1;
        exp_rdy = '0;
        g       = -1;
        if (!r) begin
            for (int i = 0; i < N; i++) begin
                c = (m_ptr + i) % N;
                if (g < 0 && v[c]) g = c;
            end
        end
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("coreReady", 64'(coreReady), 64'(exp_rdy));
        if (r) begin
            m_ptr   = 0;
            m_data  = '0;
            m_count = '0;
            rec.v   = 1'b0;
            rec.t   = 1'b0;
        end else begin
            rec.v = (g >= 0);
            rec.t = slow;
            if (g >= 0) begin
                m_data  = coreData[g*W +: W];
                m_count = m_count + 1;
                m_ptr   = (g + 1) % N;
            end
        end
        rec.d = m_data;
        rec.c = m_count;
        sb.push_back(rec);
    endtask

    // Monitor: one prediction per clock edge, compared just after the edge.
    always @(posedge clk) begin
        rec_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("outValid", 64'(outValid), 64'(e.v));
            chk("outData", outData, e.d);
            chk("resultCount", 64'(resultCount), 64'(e.c));
            chk("coreThrottle", 64'(coreThrottle), 64'(e.t));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst        = 1'b1;
        coreValid  = '0;
        coreData   = '0;
        bufferSlow = 1'b0;

        // Reset (with requests present) then idle.
        step(1'b1, 4'hF, 1'b0);
        step(1'b1, 4'h0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 4'h0, 1'b0);

        // Single core 2 with a known word.
        use_fixed  = 1'b1;
        fixed_data = 64'hDEAD_BEEF_0000_0002;
        step(1'b0, 4'b0100, 1'b0);
        use_fixed  = 1'b0;
        step(1'b0, 4'h0, 1'b0);

        // Bring pointer to 0 via core 3, then all cores valid for 8 cycles.
        step(1'b0, 4'b1000, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 4'hF, 1'b0);

        // Pointer to 2 via core 1, then cores 1 and 3 competing.
        step(1'b0, 4'b0010, 1'b0);
        step(1'b0, 4'b1010, 1'b0);
        step(1'b0, 4'b1010, 1'b0);
        step(1'b0, 4'b0100, 1'b0);

        // Throttle follows bufferSlow one cycle later; grants carry on.
        step(1'b0, 4'hF, 1'b0);
        step(1'b0, 4'hF, 1'b1);
        step(1'b0, 4'hF, 1'b1);
        step(1'b0, 4'hF, 1'b0);
        step(1'b0, 4'hF, 1'b0);

        // Reset in a cycle where core 0 would win; search restarts at core 0.
        step(1'b1, 4'b0001, 1'b1);
        step(1'b0, 4'hF, 1'b0);
        step(1'b0, 4'hF, 1'b0);

        // Random traffic with occasional reset.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 39) == 0), N'($urandom), 1'($urandom));
        end
        step(1'b0, 4'h0, 1'b0);

        @(posedge clk);
        #2;
        chk("scoreboard_drained", 64'(sb.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
